// File: rtl/osiris_i.sv
// osiris_i: UART host link that writes and reads two 256-word memories over an internal Wishbone bus.
module osiris_uart_rx #(
    parameter int CLKS = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       rx_i,
    output logic       valid_o,
    output logic [7:0] byte_o
);
    localparam int CW = $clog2(CLKS + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS / 2 - 1);
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    rx_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic valid_q, valid_d;
    logic s1_q, s2_q, s3_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            {s1_q, s2_q, s3_q} <= 3'b111;
            state_q <= R_IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            {s1_q, s2_q, s3_q} <= {rx_i, s1_q, s2_q};
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end
    // s3_q only holds the previous synchronised level for start-edge detection
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q + 1'b1;
        bit_d = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        case (state_q)
            R_IDLE: begin
                cnt_d = '0;
                if (s3_q && !s2_q) state_d = R_START;
            end
            R_START: if (cnt_q == HALF) begin
                cnt_d = '0;
                bit_d = '0;
                state_d = s2_q ? R_IDLE : R_DATA;
            end
            R_DATA: if (cnt_q == FULL) begin
                cnt_d = '0;
                shift_d = {s2_q, shift_q[7:1]};
                bit_d = bit_q + 1'b1;
                if (bit_q == 3'd7) state_d = R_STOP;
            end
            R_STOP: if (cnt_q == FULL) begin
                valid_d = s2_q;
                state_d = R_IDLE;
            end
            default: state_d = R_IDLE;
        endcase
        if (!en_i) begin
            state_d = R_IDLE;
            valid_d = 1'b0;
        end
    end
    assign valid_o = valid_q;
    assign byte_o = shift_q;
endmodule

module osiris_uart_tx #(
    parameter int CLKS = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       busy_o,
    output logic       tx_o
);
    localparam int CW = $clog2(CLKS + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS - 1);
    logic busy_q;
    logic [CW-1:0] cnt_q;
    logic [3:0] bit_q;
    logic [9:0] shift_q;
    // ones shift in behind the frame, so shift_q[0] is also the idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q <= '0;
            bit_q <= '0;
            shift_q <= '1;
        end else if (!busy_q) begin
            if (start_i) begin
                busy_q <= 1'b1;
                cnt_q <= '0;
                bit_q <= '0;
                shift_q <= {1'b1, byte_i, 1'b0};
            end
        end else if (cnt_q == FULL) begin
            cnt_q <= '0;
            shift_q <= {1'b1, shift_q[9:1]};
            bit_q <= bit_q + 1'b1;
            if (bit_q == 4'd9) busy_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
    assign busy_o = busy_q;
    assign tx_o = shift_q[0];
endmodule

module osiris_mem #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cyc_i,
    input  logic          stb_i,
    input  logic          we_i,
    input  logic [DW/8-1:0] sel_i,
    input  logic [AW-1:0] adr_i,
    input  logic [DW-1:0] dat_i,
    output logic          ack_o,
    output logic [DW-1:0] dat_o
);
    logic [DW-1:0] mem_q [256] = '{default: '0};
    logic [DW-1:0] dat_q, wmask;
    logic ack_q, req;
    logic [7:0] idx;
    logic unused;
    assign unused = ^{adr_i[AW-1:10], adr_i[1:0]};
    assign idx = adr_i[9:2];
    assign req = cyc_i && stb_i && !ack_q;
    always_comb begin
        wmask = '0;
        for (int b = 0; b < DW / 8; b++) wmask[8*b +: 8] = {8{sel_i[b]}};
    end
    always_ff @(posedge clk) begin
        ack_q <= rst ? 1'b0 : req;
        if (req) dat_q <= mem_q[idx];
        if (req && we_i && !rst) mem_q[idx] <= (mem_q[idx] & ~wmask) | (dat_i & wmask);
    end
    assign ack_o = ack_q;
    assign dat_o = dat_q;
endmodule

module osiris_uart_wb_bridge #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_valid_i,
    input  logic [7:0]      rx_byte_i,
    input  logic            tx_busy_i,
    output logic            tx_start_o,
    output logic [7:0]      tx_byte_o,
    input  logic            wb_ack_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o
);
    localparam int NA = AW / 8;
    localparam int ND = DW / 8;
    localparam int NB = NA > ND ? NA : ND;
    localparam int CW = $clog2(NB + 1);
    localparam logic [7:0] CMD_WRITE = 8'hAA;
    localparam logic [7:0] CMD_READ = 8'h01;
    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, MEM_WRITE, MEM_READ, SEND_DATA} state_t;
    state_t state, state_d;
    logic write_q, write_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            write_q <= 1'b0;
            cnt_q <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_d;
            write_q <= write_d;
            cnt_q <= cnt_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end
    // address and data shift in from the top so the first (LSB) byte lands at the bottom
    always_comb begin
        state_d = state;
        write_d = write_q;
        cnt_d = cnt_q;
        addr_d = addr_q;
        data_d = data_q;
        tx_start_o = 1'b0;
        case (state)
            IDLE: if (rx_valid_i && (rx_byte_i == CMD_WRITE || rx_byte_i == CMD_READ)) begin
                state_d = GET_ADDR;
                write_d = rx_byte_i == CMD_WRITE;
                cnt_d = '0;
            end
            GET_ADDR: if (rx_valid_i) begin
                addr_d = (addr_q >> 8) | (AW'(rx_byte_i) << (AW - 8));
                cnt_d = cnt_q == CW'(NA - 1) ? '0 : cnt_q + 1'b1;
                if (cnt_q == CW'(NA - 1)) state_d = write_q ? GET_DATA : MEM_READ;
            end
            GET_DATA: if (rx_valid_i) begin
                data_d = (data_q >> 8) | (DW'(rx_byte_i) << (DW - 8));
                cnt_d = cnt_q == CW'(ND - 1) ? '0 : cnt_q + 1'b1;
                if (cnt_q == CW'(ND - 1)) state_d = MEM_WRITE;
            end
            MEM_WRITE: if (wb_ack_i) state_d = IDLE;
            MEM_READ: if (wb_ack_i) begin
                data_d = wb_dat_i;
                cnt_d = '0;
                state_d = SEND_DATA;
            end
            SEND_DATA: if (!tx_busy_i) begin
                if (cnt_q == CW'(ND)) begin
                    state_d = IDLE;
                end else begin
                    tx_start_o = 1'b1;
                    data_d = data_q >> 8;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign tx_byte_o = data_q[7:0];
    assign wb_cyc_o = state == MEM_WRITE || state == MEM_READ;
    assign wb_stb_o = wb_cyc_o;
    assign wb_we_o = state == MEM_WRITE;
    assign wb_sel_o = '1;
    assign wb_adr_o = addr_q;
    assign wb_dat_o = data_q;
endmodule

module osiris_i #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BAUD_RATE = 9600,
    parameter int CLOCK_FREQ = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_uart_rx,
    output logic o_uart_tx,
    input  logic i_select_mem,
    input  logic i_start_rx
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    logic rx_valid, tx_start, tx_busy;
    logic [7:0] rx_byte, tx_byte;
    logic wb_cyc, wb_stb, wb_we, wb_ack, imem_ack, dmem_ack;
    logic [DATA_WIDTH/8-1:0] wb_sel;
    logic [ADDR_WIDTH-1:0] wb_adr;
    logic [DATA_WIDTH-1:0] wb_wdat, wb_rdat, imem_dat, dmem_dat;
    osiris_uart_rx #(.CLKS(CLKS_PER_BIT)) u_rx (
        .clk(clk), .rst(rst), .en_i(i_start_rx), .rx_i(i_uart_rx), .valid_o(rx_valid), .byte_o(rx_byte)
    );
    osiris_uart_tx #(.CLKS(CLKS_PER_BIT)) u_tx (
        .clk(clk), .rst(rst), .start_i(tx_start), .byte_i(tx_byte), .busy_o(tx_busy), .tx_o(o_uart_tx)
    );
    osiris_uart_wb_bridge #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) U_UART_WB_BRIDGE (
        .clk(clk), .rst(rst), .rx_valid_i(rx_valid), .rx_byte_i(rx_byte), .tx_busy_i(tx_busy),
        .tx_start_o(tx_start), .tx_byte_o(tx_byte), .wb_ack_i(wb_ack), .wb_dat_i(wb_rdat),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_sel_o(wb_sel),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_wdat)
    );
    osiris_mem #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_imem (
        .clk(clk), .rst(rst), .cyc_i(wb_cyc), .stb_i(wb_stb && !i_select_mem), .we_i(wb_we),
        .sel_i(wb_sel), .adr_i(wb_adr), .dat_i(wb_wdat), .ack_o(imem_ack), .dat_o(imem_dat)
    );
    osiris_mem #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_dmem (
        .clk(clk), .rst(rst), .cyc_i(wb_cyc), .stb_i(wb_stb && i_select_mem), .we_i(wb_we),
        .sel_i(wb_sel), .adr_i(wb_adr), .dat_i(wb_wdat), .ack_o(dmem_ack), .dat_o(dmem_dat)
    );
    assign wb_ack = imem_ack || dmem_ack;
    assign wb_rdat = dmem_ack ? dmem_dat : imem_dat;
endmodule

// File: tb/tb_osiris_i.sv
// tb_osiris_i: directed UART frames in, expected TX bytes checked by a decoupled scoreboard monitor.
module tb_osiris_i;
    localparam int CLKS = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic sel = 1'b0;
    logic en = 1'b1;
    logic tx;
    int passed = 0;
    int total = 0;
    logic [7:0] exp_q [$];

    osiris_i #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BAUD_RATE(100_000), .CLOCK_FREQ(1_600_000)) dut (
        .clk(clk), .rst(rst), .i_uart_rx(rx), .o_uart_tx(tx), .i_select_mem(sel), .i_start_rx(en)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    initial begin
        logic [7:0] b;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                repeat (CLKS / 2 - 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLKS) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CLKS) @(negedge clk);
                check("tx_stop", {31'd0, tx}, 32'd1);
                if (exp_q.size() == 0) begin
                    check("tx_extra", {24'd0, b}, 32'h100);
                end else begin
                    want = exp_q.pop_front();
                    check("tx_byte", {24'd0, b}, {24'd0, want});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLKS) @(negedge clk);
        end
        rx = stop;
        repeat (CLKS) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (32'(dut.U_UART_WB_BRIDGE.state) != 32'd0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(dut.U_UART_WB_BRIDGE.state), 32'd0);
    endtask

    task automatic write_frame(input logic s, input logic [31:0] a, input logic [31:0] d);
        sel = s;
        send_byte(8'hAA);
        send_word(a);
        send_word(d);
        wait_idle("wr_idle");
    endtask

    task automatic read_frame(input logic s, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        sel = s;
        for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
        send_byte(8'h01);
        send_word(a);
        while (exp_q.size() != 0 && n < 60 * CLKS) begin
            @(negedge clk);
            n++;
        end
        check("rd_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (CLKS) @(negedge clk);
        wait_idle("rd_idle");
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_state", 32'(dut.U_UART_WB_BRIDGE.state), 32'd0);
        check("rst_cyc", {31'd0, dut.wb_cyc}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) write_frame(1'b0, 32'(4 * i), 32'h93 + 32'(i));
        for (int i = 0; i < 4; i++) read_frame(1'b0, 32'(4 * i), 32'h93 + 32'(i));
        write_frame(1'b1, 32'h0, 32'hA5A5_A5A5);
        read_frame(1'b1, 32'h0, 32'hA5A5_A5A5);
        read_frame(1'b0, 32'h0, 32'h0000_0093);
        read_frame(1'b0, 32'h0000_040C, 32'h0000_0096);
        read_frame(1'b0, 32'hFFFF_FC03, 32'h0000_0093);
        send_byte(8'h55);
        repeat (8) @(negedge clk);
        check("junk_idle", 32'(dut.U_UART_WB_BRIDGE.state), 32'd0);
        write_frame(1'b0, 32'h20, 32'h1234_5678);
        read_frame(1'b0, 32'h20, 32'h1234_5678);
        en = 1'b0;
        write_frame(1'b0, 32'h24, 32'hCAFE_F00D);
        en = 1'b1;
        repeat (CLKS) @(negedge clk);
        read_frame(1'b0, 32'h24, 32'h0);
        sel = 1'b0;
        send_byte(8'hAA);
        send_byte(8'h14);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (4) @(negedge clk);
        check("partial_state", 32'(dut.U_UART_WB_BRIDGE.state), 32'd1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_state", 32'(dut.U_UART_WB_BRIDGE.state), 32'd0);
        check("abort_tx", {31'd0, tx}, 32'd1);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        write_frame(1'b0, 32'h10, 32'hDEAD_BEEF);
        read_frame(1'b0, 32'h10, 32'hDEAD_BEEF);
        read_frame(1'b0, 32'h14, 32'h0);
        send_byte(8'hAA, 1'b0);
        repeat (2 * CLKS) @(negedge clk);
        check("frame_err_state", 32'(dut.U_UART_WB_BRIDGE.state), 32'd0);
        read_frame(1'b0, 32'h4, 32'h0000_0094);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/osiris_i.md
OSIRIS_I -- requirements
Module: osiris_i

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of the address field in the host protocol.
REQ-003 SHALL have parameter BAUD_RATE, default 9600, UART bit rate.
REQ-004 SHALL have parameter CLOCK_FREQ, default 50000000, clk frequency in Hz.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-007 SHALL have port i_uart_rx, input, 1 bit, UART receive line (idle high).
REQ-008 SHALL have port o_uart_tx, output, 1 bit, UART transmit line (idle high).
REQ-009 SHALL have port i_select_mem, input, 1 bit: 0 selects instruction memory, 1 selects data memory.
REQ-010 SHALL have port i_start_rx, input, 1 bit: 1 enables UART reception; 0 ignores i_uart_rx.
REQ-011 SHALL contain the bridge instance U_UART_WB_BRIDGE, with state register `state` and state constant `IDLE`, reachable hierarchically by benches.

Function
REQ-012 UART SHALL be 8N1, LSB first, with bit period CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE cycles (5208 at default values).
REQ-013 Receiver SHALL synchronise i_uart_rx through 2 flops.
REQ-014 Receiver SHALL detect a start bit on a falling edge and recheck it at mid-bit (discard if high).
REQ-015 Receiver SHALL sample data bits at mid-bit and emit a 1-cycle byte-valid pulse at mid-stop-bit.
REQ-016 A stop bit sampled low (framing error) SHALL discard the byte with no valid pulse.
REQ-017 While i_start_rx=0, the receiver SHALL remain idle and produce no bytes.
REQ-018 Bridge FSM states SHALL be: IDLE, GET_ADDR, GET_DATA, MEM_WRITE, MEM_READ, SEND_DATA.
REQ-019 IDLE: byte 0xAA (CMD_WRITE) or 0x01 (CMD_READ) SHALL go to GET_ADDR and latch the command; any other byte SHALL be ignored, staying in IDLE.
REQ-020 GET_ADDR SHALL collect ADDR_WIDTH/8 bytes LSB first, then go to GET_DATA (write) or MEM_READ (read).
REQ-021 GET_DATA SHALL collect DATA_WIDTH/8 bytes LSB first, then go to MEM_WRITE.
REQ-022 MEM_WRITE SHALL issue a single Wishbone write (cyc/stb/we, sel=4'hF) to the memory selected by i_select_mem sampled in that cycle, and SHALL return to IDLE on ack.
REQ-023 Memories SHALL ack one cycle after stb, so IDLE is re-entered at most 3 cycles after the last data byte's valid pulse.
REQ-024 MEM_READ SHALL issue a Wishbone read to the memory selected by i_select_mem, latch the data on ack, and go to SEND_DATA.
REQ-025 SEND_DATA SHALL transmit DATA_WIDTH/8 bytes LSB first, back-to-back, starting within 2 cycles of entry, then return to IDLE.
REQ-026 Bytes received outside IDLE/GET_ADDR/GET_DATA (including during SEND_DATA) SHALL be dropped.
REQ-027 Instruction and data memories SHALL each be 256 x DATA_WIDTH, word-addressed by address[9:2].
REQ-028 Address bits [1:0] and [ADDR_WIDTH-1:10] SHALL be ignored, so addresses wrap modulo 1 KiB.
REQ-029 A write SHALL affect only the selected memory.
REQ-030 Memory contents SHALL NOT be cleared by rst; in simulation they SHALL initialise to 0.
REQ-031 No inter-byte timeout SHALL exist; an incomplete frame SHALL wait indefinitely for its remaining bytes or for rst.

Reset
REQ-032 While rst=1: bridge state = IDLE, byte counters = 0, Wishbone cyc/stb = 0, o_uart_tx = 1, receiver idle.
REQ-033 rst asserted mid-frame or mid-transmission SHALL abort the operation with no memory write, and the transmitter SHALL drive 1 from the next cycle.
REQ-034 After rst deasserts, the next byte SHALL be interpreted as a command.

Verification
REQ-035 Write CMD_WRITE frames to imem (i_select_mem=0) at 0x0,0x4,0x8,0xC with 0x93,0x94,0x95,0x96 -> state reaches IDLE after each; CMD_READ of each address returns 4 TX bytes equal to the written word, LSB first.
REQ-036 Write 0xA5A5A5A5 to dmem address 0x0 (i_select_mem=1), then read it -> TX bytes A5 A5 A5 A5; read imem address 0x0 -> returns 0x00000093 (isolation).
REQ-037 Send byte 0x55 followed by a valid write frame -> 0x55 is ignored and the write succeeds.
REQ-038 With i_start_rx=0, send a full write frame -> memory unchanged and state stays IDLE.
REQ-039 Assert rst after 3 address bytes, then send a fresh write to 0x10 with 0xDEADBEEF -> readback is 0xDEADBEEF and no stray write occurs.
REQ-040 Send a byte with the stop bit held low -> byte discarded and state unchanged.
